// File: rtl/uni_shift_reg_p.sv
// rtl/uni_shift_reg_p.sv - parametrised universal shift register with word counter (rotate modes gated by USR_ROTATE_EN)
module uni_shift_reg_p #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             word_done,
    output logic             mode_err
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] MODE_HOLD  = 3'd0;
    localparam logic [2:0] MODE_SHR   = 3'd1;
    localparam logic [2:0] MODE_SHL   = 3'd2;
    localparam logic [2:0] MODE_LOAD  = 3'd3;
    localparam logic [2:0] MODE_ROTR  = 3'd4;
    localparam logic [2:0] MODE_ROTL  = 3'd5;
    localparam logic [2:0] MODE_ASR   = 3'd6;
    localparam logic [2:0] MODE_CLEAR = 3'd7;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    // Architectural state
    logic [WIDTH-1:0] data_q,      data_d;
    logic             sout_r_q,    sout_r_d;
    logic             sout_l_q,    sout_l_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             dir_q,       dir_d;
    logic             word_done_q, word_done_d;
    logic             mode_err_q,  mode_err_d;

    // Decoded operation class for this cycle
    logic             shift_valid;
    logic             shift_dir;
    logic             cnt_clear;
    logic             bad_mode;
    logic [CW-1:0]    cnt_inc;

    // Data path: next register contents and serial-out bits
    always_comb begin
        data_d   = data_q;
        sout_r_d = sout_r_q;
        sout_l_d = sout_l_q;
        if (en) begin
            case (mode)
                MODE_SHR: begin
                    data_d   = {sin_r, data_q[WIDTH-1:1]};
                    sout_r_d = data_q[0];
                end
                MODE_SHL: begin
                    data_d   = {data_q[WIDTH-2:0], sin_l};
                    sout_l_d = data_q[WIDTH-1];
                end
                MODE_LOAD: begin
                    data_d = din;
                end
`ifdef USR_ROTATE_EN
                MODE_ROTR: begin
                    data_d   = {data_q[0], data_q[WIDTH-1:1]};
                    sout_r_d = data_q[0];
                end
                MODE_ROTL: begin
                    data_d   = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                    sout_l_d = data_q[WIDTH-1];
                end
`endif
                MODE_ASR: begin
                    data_d   = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                    sout_r_d = data_q[0];
                end
                MODE_CLEAR: begin
                    data_d = RST_VAL;
                end
                default: begin
                    // HOLD, and rotates in a build without rotate support
                end
            endcase
        end
    end

    // Classify the op: which shifts count toward a word, which ops clear the count
    always_comb begin
        shift_valid = 1'b0;
        shift_dir   = DIR_RIGHT;
        cnt_clear   = 1'b0;
        bad_mode    = 1'b0;
        if (en) begin
            case (mode)
                MODE_SHR, MODE_ASR: begin
                    shift_valid = 1'b1;
                    shift_dir   = DIR_RIGHT;
                end
                MODE_SHL: begin
                    shift_valid = 1'b1;
                    shift_dir   = DIR_LEFT;
                end
                MODE_ROTR: begin
`ifdef USR_ROTATE_EN
                    shift_valid = 1'b1;
                    shift_dir   = DIR_RIGHT;
`else
                    bad_mode    = 1'b1;
`endif
                end
                MODE_ROTL: begin
`ifdef USR_ROTATE_EN
                    shift_valid = 1'b1;
                    shift_dir   = DIR_LEFT;
`else
                    bad_mode    = 1'b1;
`endif
                end
                MODE_LOAD, MODE_CLEAR: begin
                    cnt_clear = 1'b1;
                end
                default: begin
                    // HOLD leaves the counter alone
                end
            endcase
        end
    end

    // Word counter: restart on direction change, wrap and pulse at WIDTH
    always_comb begin
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        word_done_d = 1'b0;
        cnt_inc     = (shift_dir == dir_q) ? (cnt_q + CNT_ONE) : CNT_ONE;
        if (cnt_clear) begin
            cnt_d = '0;
        end else if (shift_valid) begin
            dir_d = shift_dir;
            if (cnt_inc == CNT_FULL) begin
                cnt_d       = '0;
                word_done_d = 1'b1;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    // Unsupported-mode flag; only rotates can be unsupported
    always_comb begin
`ifdef USR_ROTATE_EN
        mode_err_d = 1'b0;
`else
        mode_err_d = bad_mode;
`endif
    end

    // State register with synchronous reset overriding en/mode
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q      <= RST_VAL;
            sout_r_q    <= 1'b0;
            sout_l_q    <= 1'b0;
            cnt_q       <= '0;
            dir_q       <= DIR_RIGHT;
            word_done_q <= 1'b0;
            mode_err_q  <= 1'b0;
        end else begin
            data_q      <= data_d;
            sout_r_q    <= sout_r_d;
            sout_l_q    <= sout_l_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            word_done_q <= word_done_d;
            mode_err_q  <= mode_err_d;
        end
    end

    assign q         = data_q;
    assign sout_r    = sout_r_q;
    assign sout_l    = sout_l_q;
    assign word_done = word_done_q;
    assign mode_err  = mode_err_q;

endmodule

// File: tb/tb_uni_shift_reg_p.sv
// tb/tb_uni_shift_reg_p.sv - directed self-checking bench for uni_shift_reg_p (honours USR_ROTATE_EN)
module tb_uni_shift_reg_p;

    localparam logic [2:0] HOLD = 3'd0, SHR = 3'd1, SHL = 3'd2, LOAD = 3'd3;
    localparam logic [2:0] ROTR = 3'd4, ROTL = 3'd5, ASR = 3'd6, CLEAR = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] din = 8'h00;
    logic       sin_r = 1'b0;
    logic       sin_l = 1'b0;

    logic [7:0] q, q2;
    logic       sout_r, sout_l, word_done, mode_err;
    logic       sout_r2, sout_l2, word_done2, mode_err2;

    int checks = 0;
    int errors = 0;

    logic [7:0] seq;
    logic [7:0] qs [8];

    always #5 clk = ~clk;

    uni_shift_reg_p #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din),
        .sin_r(sin_r), .sin_l(sin_l), .q(q), .sout_r(sout_r), .sout_l(sout_l),
        .word_done(word_done), .mode_err(mode_err)
    );

    uni_shift_reg_p #(.WIDTH(8), .RST_VAL(8'h3C)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din),
        .sin_r(sin_r), .sin_l(sin_l), .q(q2), .sout_r(sout_r2), .sout_l(sout_l2),
        .word_done(word_done2), .mode_err(mode_err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge
    task automatic op(input logic [2:0] m, input logic [7:0] d, input logic sr, input logic sl);
        mode  = m;
        din   = d;
        sin_r = sr;
        sin_l = sl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        // 1: reset overrides en=1/LOAD
        rst = 1'b1; en = 1'b1;
        op(LOAD, 8'hFF, 1'b0, 1'b0);
        op(LOAD, 8'hFF, 1'b0, 1'b0);
        chk("rst_q", q, 8'h00);
        chk("rst_sout_r", sout_r, 1'b0);
        chk("rst_sout_l", sout_l, 1'b0);
        chk("rst_word_done", word_done, 1'b0);
        chk("rst_mode_err", mode_err, 1'b0);
        chk("rst_q_rv3c", q2, 8'h3C);
        rst = 1'b0;

        // 2: LOAD A5 then 8x SHR with sin_r=1
        op(LOAD, 8'hA5, 1'b0, 1'b0);
        chk("t2_load", q, 8'hA5);
        seq = 8'hA5;
        qs = '{8'hD2, 8'hE9, 8'hF4, 8'hFA, 8'hFD, 8'hFE, 8'hFF, 8'hFF};
        for (int i = 0; i < 8; i++) begin
            op(SHR, 8'h00, 1'b1, 1'b0);
            chk("t2_sout_r", sout_r, seq[7-i]);
            chk("t2_q", q, qs[i]);
            chk("t2_word_done", word_done, (i == 7));
        end
        op(HOLD, 8'h00, 1'b0, 1'b0);
        chk("t2_hold_q", q, 8'hFF);
        chk("t2_wd_single", word_done, 1'b0);

        // 3: ASR sign extension, then direction change restarts the count
        op(LOAD, 8'h81, 1'b0, 1'b0);
        op(ASR, 8'h00, 1'b0, 1'b0);
        chk("t3_asr1", q, 8'hC0);
        chk("t3_asr1_sout_r", sout_r, 1'b1);
        op(ASR, 8'h00, 1'b0, 1'b0);
        chk("t3_asr2", q, 8'hE0);
        op(ASR, 8'h00, 1'b0, 1'b0);
        chk("t3_asr3", q, 8'hF0);
        chk("t3_asr3_sout_r", sout_r, 1'b0);
        op(SHL, 8'h00, 1'b0, 1'b0);
        chk("t3_shl_q", q, 8'hE0);
        chk("t3_shl_sout_l", sout_l, 1'b1);
        chk("t3_shl_sout_r_kept", sout_r, 1'b0);
        for (int i = 0; i < 7; i++) begin
            op(SHL, 8'h00, 1'b0, 1'b0);
            chk("t3_restart_wd", word_done, (i == 6));
        end

        // 4a: en=0 gap inside a word does not disturb the count
        op(LOAD, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            op(SHL, 8'h00, 1'b0, 1'b1);
            chk("t4_wd_a", word_done, 1'b0);
        end
        chk("t4_q5", q, 8'h1F);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op(ROTR, 8'hAA, 1'b1, 1'b1);
            chk("t4_en0_q", q, 8'h1F);
            chk("t4_en0_err", mode_err, 1'b0);
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op(SHL, 8'h00, 1'b0, 1'b1);
            chk("t4_wd_b", word_done, (i == 2));
        end
        chk("t4_q8", q, 8'hFF);

        // 4b: LOAD inside a word clears the count
        for (int i = 0; i < 5; i++) op(SHL, 8'h00, 1'b0, 1'b0);
        op(LOAD, 8'h0F, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            op(SHL, 8'h00, 1'b0, 1'b0);
            chk("t4_load_no_wd", word_done, 1'b0);
        end
        chk("t4_load_q", q, 8'h78);

`ifdef USR_ROTATE_EN
        // 5 (rotate build)
        op(LOAD, 8'h01, 1'b0, 1'b0);
        op(ROTR, 8'h00, 1'b0, 1'b0);
        chk("t5_rotr_q", q, 8'h80);
        chk("t5_rotr_sout_r", sout_r, 1'b1);
        chk("t5_rotr_err", mode_err, 1'b0);
        op(ROTL, 8'h00, 1'b0, 1'b0);
        chk("t5_rotl1_q", q, 8'h01);
        chk("t5_rotl1_sout_l", sout_l, 1'b1);
        op(ROTL, 8'h00, 1'b0, 1'b0);
        chk("t5_rotl2_q", q, 8'h02);
        chk("t5_rotl2_sout_l", sout_l, 1'b0);
`else
        // 5 (no rotate build): rotates are rejected and leave everything alone
        op(LOAD, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) op(SHR, 8'h00, 1'b1, 1'b0);
        chk("t5_pre_q", q, 8'hF0);
        op(ROTR, 8'h00, 1'b0, 1'b0);
        chk("t5_rotr_q", q, 8'hF0);
        chk("t5_rotr_err", mode_err, 1'b1);
        chk("t5_rotr_sout_r", sout_r, 1'b0);
        op(HOLD, 8'h00, 1'b0, 1'b0);
        chk("t5_err_pulse", mode_err, 1'b0);
        op(ROTL, 8'h00, 1'b0, 1'b0);
        chk("t5_rotl_q", q, 8'hF0);
        chk("t5_rotl_err", mode_err, 1'b1);
        chk("t5_rotl_sout_l", sout_l, 1'b0);
        for (int i = 0; i < 4; i++) begin
            op(SHR, 8'h00, 1'b0, 1'b0);
            chk("t5_cnt_kept_wd", word_done, (i == 3));
        end
        chk("t5_err_clear", mode_err, 1'b0);
`endif

        // 6: mid-word reset discards the partial count
        op(LOAD, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) op(SHR, 8'h00, 1'b1, 1'b0);
        rst = 1'b1;
        op(SHR, 8'h00, 1'b1, 1'b0);
        rst = 1'b0;
        chk("t6_rst_q", q, 8'h00);
        chk("t6_rst_q_rv3c", q2, 8'h3C);
        for (int i = 0; i < 8; i++) begin
            op(SHR, 8'h00, 1'b0, 1'b0);
            chk("t6_wd", word_done, (i == 7));
        end
        chk("t6_q2_end", q2, 8'h00);
        op(LOAD, 8'hA5, 1'b0, 1'b0);
        op(CLEAR, 8'h00, 1'b0, 1'b0);
        chk("t6_clear_q", q, 8'h00);
        chk("t6_clear_q_rv3c", q2, 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
